// File: rtl/pattern_sequencer_pkg.sv
// Shared types and the rate-period helper for the LED pattern sequencer.
package pattern_seq_pkg;

    typedef enum logic [1:0] {
        LOOP     = 2'd0,
        PINGPONG = 2'd1,
        ONESHOT  = 2'd2,
        HOLD     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        LATCH = 2'd2
    } fetch_state_t;

    // Tick period in clocks; the fastest rate (highest index) uses base_div.
    function automatic int unsigned rate_period(input int unsigned base_div,
                                                input int unsigned rate_w,
                                                input int unsigned freq);
        return base_div << (((32'd1 << rate_w) - 32'd1) - freq);
    endfunction

endpackage

// File: rtl/pattern_sequencer_rate_divider.sv
// Step-rate generator: saturating rate index and a reloadable down-counter tick.
module rate_divider
    import pattern_seq_pkg::*;
#(
    parameter int unsigned BASE_DIV     = 50000,
    parameter int unsigned RATE_W       = 3,
    parameter int unsigned DEFAULT_RATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freq_up,
    input  logic              freq_dn,
    input  logic              reload,
    output logic [RATE_W-1:0] freq_num,
    output logic              tick
);

    localparam int unsigned CNT_W = $clog2(rate_period(BASE_DIV, RATE_W, 0));

    logic [CNT_W-1:0]  cnt;
    logic [RATE_W-1:0] freq_next;

    always_comb begin
        freq_next = freq_num;
        if (freq_up && !freq_dn && freq_num != '1)
            freq_next = freq_num + 1'b1;
        else if (freq_dn && !freq_up && freq_num != '0)
            freq_next = freq_num - 1'b1;
    end

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_num <= RATE_W'(DEFAULT_RATE);
            cnt      <= CNT_W'(rate_period(BASE_DIV, RATE_W, DEFAULT_RATE) - 32'd1);
        end else begin
            freq_num <= freq_next;
            // A rate change always restarts the period at the new rate.
            if (freq_next != freq_num || reload)
                cnt <= CNT_W'(rate_period(BASE_DIV, RATE_W, 32'(freq_next)) - 32'd1);
            else if (tick)
                cnt <= CNT_W'(rate_period(BASE_DIV, RATE_W, 32'(freq_num)) - 32'd1);
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// LED pattern sequencer: step addressing, play modes and a ROM fetch pipeline.
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned STEP_W       = 4,
    parameter int unsigned SEQ_W        = 6,
    parameter int unsigned RATE_W       = 3,
    parameter int unsigned BASE_DIV     = 50000,
    parameter int unsigned DEFAULT_RATE = 0,
    parameter int unsigned ROM_LAT      = 2
) (
    input  logic                    CLK_50,
    input  logic                    reset_n,
    input  logic                    freq_up,
    input  logic                    freq_dn,
    input  logic                    seq_up,
    input  logic                    seq_dn,
    input  logic [1:0]              mode,
    output logic [SEQ_W+STEP_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [DATA_W-1:0]       pattern_out,
    output logic                    pattern_valid,
    output logic [SEQ_W-1:0]        seq_num,
    output logic [RATE_W-1:0]       freq_num,
    output logic [STEP_W-1:0]       step_idx,
    output logic                    done
);

    localparam int unsigned STEPS = 1 << STEP_W;
    localparam int unsigned LAT_W = 2;

    mode_t              play_mode;
    fetch_state_t       state, state_next;
    logic [LAT_W-1:0]   lat_cnt;
    logic [SEQ_W-1:0]   seq_next;
    logic [STEP_W-1:0]  step_next;
    logic               dir, dir_next, done_next;
    logic               started, tick, reload, fetch_req, latch_en;
    logic               seq_chg, resume;

    assign play_mode = mode_t'(mode);

    rate_divider #(
        .BASE_DIV     (BASE_DIV),
        .RATE_W       (RATE_W),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) u_rate (
        .clk      (CLK_50),
        .rst_n    (reset_n),
        .freq_up  (freq_up),
        .freq_dn  (freq_dn),
        .reload   (reload),
        .freq_num (freq_num),
        .tick     (tick)
    );

    // Priority: sequence change, resume from a finished one-shot, first fetch, tick.
    always_comb begin
        seq_next  = seq_num;
        step_next = step_idx;
        dir_next  = dir;
        done_next = done;
        fetch_req = 1'b0;
        reload    = 1'b0;
        seq_chg   = seq_up ^ seq_dn;
        resume    = done && (play_mode == LOOP || play_mode == PINGPONG);
        if (seq_chg) begin
            seq_next  = seq_up ? seq_num + 1'b1 : seq_num - 1'b1;
            step_next = '0;
            dir_next  = 1'b1;
            done_next = 1'b0;
            reload    = 1'b1;
            fetch_req = 1'b1;
        end else if (resume) begin
            step_next = '0;
            dir_next  = 1'b1;
            done_next = 1'b0;
            reload    = 1'b1;
            fetch_req = 1'b1;
        end else if (!started) begin
            fetch_req = 1'b1;
        end else if (tick) begin
            case (play_mode)
                LOOP: begin
                    step_next = step_idx + 1'b1;
                    fetch_req = 1'b1;
                end
                PINGPONG: begin
                    fetch_req = 1'b1;
                    if (STEPS == 1) begin
                        step_next = '0;
                    end else if (dir) begin
                        if (step_idx == '1) begin
                            dir_next  = 1'b0;
                            step_next = step_idx - 1'b1;
                        end else begin
                            step_next = step_idx + 1'b1;
                        end
                    end else begin
                        if (step_idx == '0) begin
                            dir_next  = 1'b1;
                            step_next = STEP_W'(1);
                        end else begin
                            step_next = step_idx - 1'b1;
                        end
                    end
                end
                ONESHOT: begin
                    if (!done) begin
                        if (step_idx == '1) begin
                            done_next = 1'b1;
                        end else begin
                            step_next = step_idx + 1'b1;
                            fetch_req = 1'b1;
                        end
                    end
                end
                HOLD: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            WAIT:    if (lat_cnt == '0) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A new request abandons whatever fetch is in flight.
        if (fetch_req)
            state_next = WAIT;
        latch_en = (state == LATCH) && !fetch_req;
    end

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            seq_num       <= '0;
            step_idx      <= '0;
            dir           <= 1'b1;
            done          <= 1'b0;
            started       <= 1'b0;
            rom_addr      <= '0;
            lat_cnt       <= '0;
            pattern_out   <= '0;
            pattern_valid <= 1'b0;
        end else begin
            seq_num       <= seq_next;
            step_idx      <= step_next;
            dir           <= dir_next;
            done          <= done_next;
            started       <= 1'b1;
            pattern_valid <= latch_en;
            if (fetch_req) begin
                rom_addr <= {seq_next, step_next};
                lat_cnt  <= LAT_W'(ROM_LAT - 1);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (latch_en)
                pattern_out <= rom_q;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: cycle model of the step/fetch rules plus directed literal checks.
module tb_pattern_sequencer;

    localparam int unsigned DATA_W = 10, STEP_W = 3, SEQ_W = 2, RATE_W = 2;
    localparam int unsigned BASE_DIV = 4, DEFAULT_RATE = 0, ROM_LAT = 2;
    localparam int unsigned AW = SEQ_W + STEP_W, STEPS = 8, NSEQ = 4, NRATES = 4;
    localparam int P_FU = 0, P_FD = 1, P_SU = 2, P_SD = 3, P_FBOTH = 4;

    logic clk = 1'b0, reset_n = 1'b1;
    logic freq_up = 1'b0, freq_dn = 1'b0, seq_up = 1'b0, seq_dn = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q, pattern_out;
    logic pattern_valid, done;
    logic [SEQ_W-1:0] seq_num;
    logic [RATE_W-1:0] freq_num;
    logic [STEP_W-1:0] step_idx;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .DATA_W(DATA_W), .STEP_W(STEP_W), .SEQ_W(SEQ_W), .RATE_W(RATE_W),
        .BASE_DIV(BASE_DIV), .DEFAULT_RATE(DEFAULT_RATE), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLK_50(clk), .reset_n(reset_n), .freq_up(freq_up), .freq_dn(freq_dn),
        .seq_up(seq_up), .seq_dn(seq_dn), .mode(mode), .rom_addr(rom_addr),
        .rom_q(rom_q), .pattern_out(pattern_out), .pattern_valid(pattern_valid),
        .seq_num(seq_num), .freq_num(freq_num), .step_idx(step_idx), .done(done)
    );

    // ROM: q equals the address presented ROM_LAT clocks earlier.
    logic [AW-1:0] rom_pipe [ROM_LAT] = '{default: '0};
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = DATA_W'(rom_pipe[ROM_LAT-1]);

    int n_checks = 0, n_fail = 0;
    bit checking_on = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model
    int m_seq = 0, m_step = 0, m_dir = 1, m_done = 0, m_freq = DEFAULT_RATE;
    int m_elapsed = 0, m_started = 0, m_addr = 0, m_pat = 0, m_valid = 0;
    int m_pend = 0, m_left = 0, m_period;
    bit m_tick, m_req, m_fchg, m_moved, m_resume;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_seq = 0; m_step = 0; m_dir = 1; m_done = 0; m_freq = DEFAULT_RATE;
            m_elapsed = 0; m_started = 0; m_addr = 0; m_pat = 0; m_valid = 0; m_pend = 0;
        end else begin
            m_period = BASE_DIV << (NRATES - 1 - m_freq);
            m_tick = (m_elapsed == m_period - 1);
            m_fchg = 0;
            if (freq_up && !freq_dn && m_freq < NRATES - 1) begin m_freq++; m_fchg = 1; end
            else if (freq_dn && !freq_up && m_freq > 0) begin m_freq--; m_fchg = 1; end
            m_moved = (seq_up != seq_dn);
            m_resume = m_done != 0 && (mode == 2'd0 || mode == 2'd1);
            if (m_fchg || m_moved || m_resume || m_tick) m_elapsed = 0;
            else m_elapsed++;
            m_req = 0;
            if (m_moved) begin
                m_seq = (m_seq + (seq_up ? 1 : NSEQ - 1)) % NSEQ;
                m_step = 0; m_dir = 1; m_done = 0; m_req = 1;
            end else if (m_resume) begin
                m_step = 0; m_dir = 1; m_done = 0; m_req = 1;
            end else if (m_started == 0) begin
                m_req = 1;
            end else if (m_tick) begin
                case (mode)
                    2'd0: begin m_step = (m_step + 1) % STEPS; m_req = 1; end
                    2'd1: begin
                        m_req = 1;
                        if (m_dir != 0) begin
                            if (m_step == STEPS - 1) begin m_dir = 0; m_step = STEPS - 2; end
                            else m_step++;
                        end else begin
                            if (m_step == 0) begin m_dir = 1; m_step = 1; end
                            else m_step--;
                        end
                    end
                    2'd2: if (m_done == 0) begin
                        if (m_step == STEPS - 1) m_done = 1;
                        else begin m_step++; m_req = 1; end
                    end
                    default: ;
                endcase
            end
            m_started = 1;
            m_valid = 0;
            if (m_req) begin
                m_addr = m_seq * STEPS + m_step; m_pend = 1; m_left = ROM_LAT + 1;
            end else if (m_pend != 0) begin
                m_left--;
                if (m_left == 0) begin m_pat = m_addr; m_valid = 1; m_pend = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (checking_on) begin
            check("rom_addr", rom_addr, m_addr);
            check("pattern_out", pattern_out, m_pat);
            check("pattern_valid", pattern_valid, m_valid);
            check("seq_num", seq_num, m_seq);
            check("freq_num", freq_num, m_freq);
            check("step_idx", step_idx, m_step);
            check("done", done, m_done);
        end
    end

    task automatic pulse(input int which);
        case (which)
            P_FU: freq_up = 1'b1;
            P_FD: freq_dn = 1'b1;
            P_SU: seq_up = 1'b1;
            P_SD: seq_dn = 1'b1;
            default: begin freq_up = 1'b1; freq_dn = 1'b1; end
        endcase
        @(negedge clk);
        freq_up = 1'b0; freq_dn = 1'b0; seq_up = 1'b0; seq_dn = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rom_addr"}, rom_addr, 0);
        check({tag, " pattern_out"}, pattern_out, 0);
        check({tag, " pattern_valid"}, pattern_valid, 0);
        check({tag, " seq_num"}, seq_num, 0);
        check({tag, " freq_num"}, freq_num, DEFAULT_RATE);
        check({tag, " step_idx"}, step_idx, 0);
        check({tag, " done"}, done, 0);
    endtask

    int pp_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int seen [$];
    int prev, cnt;

    initial begin
        #1 reset_n = 1'b0;
        #1 checking_on = 1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // LOOP at the slowest rate
        repeat (3) @(negedge clk);
        check("first valid not early", pattern_valid, 0);
        @(negedge clk);
        check("first valid", pattern_valid, 1);
        check("first pattern", pattern_out, 0);
        repeat (27) @(negedge clk);
        check("step before first tick", step_idx, 0);
        @(negedge clk);
        check("step after first tick", step_idx, 1);
        repeat (3) @(negedge clk);
        check("second valid", pattern_valid, 1);
        check("second pattern", pattern_out, 1);
        repeat (221) @(negedge clk);
        check("loop wrap", step_idx, 0);

        // Rate saturation and period
        repeat (4) pulse(P_FU);
        check("freq saturate high", freq_num, 3);
        prev = step_idx; cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (step_idx != prev) cnt++;
            prev = step_idx;
        end
        check("ticks in 40 clocks at rate 3", cnt, 10);
        repeat (5) pulse(P_FD);
        check("freq saturate low", freq_num, 0);
        pulse(P_FBOTH);
        check("freq both at 0", freq_num, 0);
        pulse(P_FU);
        pulse(P_FBOTH);
        check("freq both at 1", freq_num, 1);

        // PINGPONG
        repeat (3) pulse(P_FU);
        mode = 2'd1;
        pulse(P_SU);
        check("pp seq", seq_num, 1);
        check("pp start step", step_idx, 0);
        prev = 0;
        repeat (64) begin
            @(negedge clk);
            if (step_idx != prev) seen.push_back(int'(step_idx));
            prev = step_idx;
        end
        for (int i = 0; i < 16; i++)
            check("pingpong order", (i < seen.size()) ? seen[i] : -1, pp_exp[i]);

        // Sequence select in HOLD, then priority over a tick
        mode = 2'd3;
        pulse(P_SD);
        pulse(P_SD);
        check("seq_dn wrap", seq_num, 3);
        check("seq_dn step", step_idx, 0);
        check("seq_dn addr", rom_addr, 24);
        repeat (3) @(negedge clk);
        check("seq_dn valid", pattern_valid, 1);
        check("seq_dn pattern", pattern_out, 24);
        repeat (20) @(negedge clk);
        check("hold step", step_idx, 0);
        check("hold pattern", pattern_out, 24);
        mode = 2'd0;
        pulse(P_SU);
        repeat (3) @(negedge clk);
        pulse(P_SU);
        check("seq over tick seq", seq_num, 1);
        check("seq over tick step", step_idx, 0);
        check("seq over tick addr", rom_addr, 8);

        // ONESHOT, then resume in LOOP
        mode = 2'd2;
        pulse(P_SD);
        repeat (31) @(negedge clk);
        check("oneshot last step", step_idx, 7);
        check("oneshot not done yet", done, 0);
        @(negedge clk);
        check("oneshot done", done, 1);
        check("oneshot addr", rom_addr, 7);
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += pattern_valid; end
        check("oneshot no fetch", cnt, 0);
        check("oneshot addr held", rom_addr, 7);
        mode = 2'd0;
        @(negedge clk);
        check("resume done", done, 0);
        check("resume step", step_idx, 0);
        check("resume addr", rom_addr, 0);

        // Restart of an in-flight fetch
        pulse(P_SU);
        repeat (4) @(negedge clk);
        check("tick fetch addr", rom_addr, 9);
        pulse(P_SU);
        cnt = pattern_valid;
        repeat (3) begin @(negedge clk); cnt += pattern_valid; end
        check("restart single valid", cnt, 1);
        check("restart pattern", pattern_out, 16);

        // Reset mid-fetch
        pulse(P_SU);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post-reset valid", pattern_valid, 1);
        check("post-reset pattern", pattern_out, 0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised successor to the fixed throttle-plus-sequencer pair that drives the LED display.
- Combines the step-rate generator, the sequence/step address counter and the ROM fetch pipeline in one block.
- Adds three things the fixed pair lacks: configurable width, depth and ROM latency; selectable play modes (loop, ping-pong, one-shot, hold); and a registered pattern output with a valid strobe.
- Sits between the debouncers (pulse inputs) and the pattern ROM; pattern_out drives LEDR.

Parameters:
- DATA_W, 10: pattern word width (ROM q width).
- STEP_W, 4: log2 of steps per sequence; STEPS = 2**STEP_W.
- SEQ_W, 6: log2 of the number of sequences.
- RATE_W, 3: freq_num width; NUM_RATES = 2**RATE_W.
- BASE_DIV, 50000: tick period in clocks at the fastest rate; must be at least 2.
- DEFAULT_RATE, 0: freq_num after reset.
- ROM_LAT, 2: ROM read latency in clocks, from address to q; range 1 to 3.

Ports:
- CLK_50, in, 1: the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- freq_up, in, 1: one-cycle pulse; raise the step rate.
- freq_dn, in, 1: one-cycle pulse; lower the step rate.
- seq_up, in, 1: one-cycle pulse; select the next sequence.
- seq_dn, in, 1: one-cycle pulse; select the previous sequence.
- mode, in, 2: 0 = LOOP, 1 = PINGPONG, 2 = ONESHOT, 3 = HOLD.
- rom_addr, out, SEQ_W+STEP_W: ROM address, equal to {seq_num, step_idx}; registered.
- rom_q, in, DATA_W: ROM read data.
- pattern_out, out, DATA_W: last fetched pattern; registered.
- pattern_valid, out, 1: one-cycle pulse when pattern_out updates.
- seq_num, out, SEQ_W: current sequence.
- freq_num, out, RATE_W: current rate index; higher means faster.
- step_idx, out, STEP_W: current step.
- done, out, 1: high while a one-shot run is finished.

Behaviour:
- Reset values: rom_addr=0, pattern_out=0, pattern_valid=0, seq_num=0, freq_num=DEFAULT_RATE, step_idx=0, done=0.
- Direction is forward and the divider is loaded.
- The first cycle after reset release issues a fetch of step 0.
- Rate divider:
  - period = BASE_DIV << (NUM_RATES-1-freq_num) clocks.
  - The down-counter emits a one-cycle tick when it reaches 0, then reloads.
  - freq_up increments freq_num, saturating at NUM_RATES-1. freq_dn decrements it, saturating at 0.
  - Any change in freq_num reloads the counter with the new period.
  - freq_up and freq_dn in the same cycle are both ignored.
- Sequence select:
  - seq_up and seq_dn wrap modulo 2**SEQ_W. Both in the same cycle are ignored.
  - A change sets step_idx=0, direction forward, done=0, reloads the divider and issues a fetch.
  - A sequence change has priority over a tick in the same cycle.
- Step advance on tick:
  - LOOP: step_idx+1, wrapping STEPS-1 to 0.
  - PINGPONG: move in the current direction. At STEPS-1 going up, reverse and go to STEPS-2. At 0 going down, reverse and go to 1. End steps are shown once per bounce. STEP_W=0 stays at 0.
  - ONESHOT: step_idx+1 until STEPS-1. On the tick at STEPS-1, set done=1 and stop; no further fetches.
  - HOLD: ticks ignored. step_idx and pattern_out are frozen; a sequence change still restarts at step 0 and fetches.
- Switching mode to LOOP or PINGPONG while done=1 clears done and resumes from step 0.
- Fetch FSM, states IDLE, WAIT, LATCH:
  - A fetch request sets rom_addr={seq_num, new step_idx} on the same clock edge.
  - The FSM enters WAIT with lat_cnt=ROM_LAT-1 (go straight to LATCH if 0) and decrements to 0.
  - In LATCH: pattern_out<=rom_q, pattern_valid=1 for one cycle, then return to IDLE.
  - pattern_out therefore updates ROM_LAT+1 clocks after the requesting tick.
- A new fetch request arriving during WAIT or LATCH restarts the fetch with the new address. The stale data is discarded and no valid pulse is given for it.
- reset_n assertion mid-fetch aborts the fetch and forces all reset values immediately (asynchronously).

Decomposition:
- Package pattern_seq_pkg holds:
  - the mode_t enum (LOOP, PINGPONG, ONESHOT, HOLD);
  - the fetch_state_t enum (IDLE, WAIT, LATCH);
  - the helper function that computes the rate period.
- One sub-module, rate_divider: freq_num saturation, period reload and tick output, parametrised by BASE_DIV and RATE_W.

Test Plan:
Common bench setup: BASE_DIV=4, RATE_W=2, STEP_W=3, SEQ_W=2, ROM_LAT=2; ROM model returns rom_q = rom_addr.
1. Reset release in LOOP mode, freq_num=0 (period 32) -> pattern_valid at cycle 3 with pattern_out=0; step_idx then goes 1..7,0 on every 32nd clock; pattern_out follows 3 clocks after each tick.
2. freq_up ×4 -> freq_num saturates at 3 and the tick period is 4. freq_dn ×5 -> freq_num=0. freq_up and freq_dn in the same cycle -> freq_num unchanged.
3. PINGPONG -> step_idx sequence 0,1,…,7,6,…,0,1 with no repeated end steps.
4. seq_dn from seq 0 -> seq_num=3, step_idx=0, rom_addr=24, pattern_out=24 after 3 clocks. seq_up in the same cycle as a tick -> only the sequence change occurs.
5. ONESHOT -> steps run 0..7, then done=1, rom_addr stays 7, no further pattern_valid. Switching to LOOP -> done=0, restart at step 0.
6. Tick during WAIT of a prior fetch, and reset_n pulsed low mid-fetch -> only the newest address is latched. Reset forces all outputs to reset values within the same cycle.
